// File: rtl/sd_sector_uart_dumper_if.sv
// Bus bundle for the sector dumper: the SD reader write side and the
// UART TX FIFO write port. The dumper uses the slave view; whoever drives
// the sector bytes and grants the TX port uses the master view.
interface sd_sector_uart_dumper_if #(
   parameter int SECTOR_BYTES = 512
) ();
   localparam int ADDR_W = $clog2(SECTOR_BYTES);

   logic              in_valid;
   logic [ADDR_W-1:0] in_addr;
   logic [7:0]        in_byte;
   logic              in_done;
   logic [31:0]       in_sector;
   logic              wreq;
   logic              wgnt;
   logic [7:0]        wdata;

   modport slave (
      input  in_valid, in_addr, in_byte, in_done, in_sector, wgnt,
      output wreq, wdata
   );

   modport master (
      output in_valid, in_addr, in_byte, in_done, in_sector, wgnt,
      input  wreq, wdata
   );
endinterface

// File: rtl/sd_sector_uart_dumper.sv
// Captures one sector from the SD reader into a local buffer, then streams
// an optional "Sxxxxxxxx\r\n" header, the raw sector bytes and an optional
// "\r\n" trailer into the UART TX FIFO over a wreq/wgnt handshake.
module sd_sector_uart_dumper #(
   parameter bit HEADER_EN    = 1'b1,
   parameter bit TRAILER_EN   = 1'b1,
   parameter int SECTOR_BYTES = 512
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sd_sector_uart_dumper_if.slave bus,
   output logic                   busy,
   output logic                   overrun
);
   localparam int ADDR_W = $clog2(SECTOR_BYTES);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(SECTOR_BYTES);
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(SECTOR_BYTES - 1);

   typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;

   // ASCII for one hex nibble, uppercase letters.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Header byte at position idx: 'S', eight address digits MSB first, CR, LF.
   function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [31:0] sec);
      case (idx)
         4'd0:    return 8'h53;
         4'd1:    return hex_ascii(sec[31:28]);
         4'd2:    return hex_ascii(sec[27:24]);
         4'd3:    return hex_ascii(sec[23:20]);
         4'd4:    return hex_ascii(sec[19:16]);
         4'd5:    return hex_ascii(sec[15:12]);
         4'd6:    return hex_ascii(sec[11:8]);
         4'd7:    return hex_ascii(sec[7:4]);
         4'd8:    return hex_ascii(sec[3:0]);
         4'd9:    return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   state_t            r_state;
   logic              r_wreq;
   logic [7:0]        r_wdata;
   logic [3:0]        r_hidx;
   logic              r_tidx;
   logic [31:0]       r_sector;
   logic [ADDR_W:0]   r_fetch_addr;
   logic [ADDR_W:0]   r_cnt;
   logic              r_q_valid;
   logic [7:0]        r_rd_q;
   logic              r_overrun;
   logic [7:0]        r_mem [SECTOR_BYTES];

   state_t            w_state_nxt;
   logic              w_wreq_nxt;
   logic [7:0]        w_wdata_nxt;
   logic [3:0]        w_hidx_nxt;
   logic              w_tidx_nxt;
   logic              w_take;
   logic              w_fetch;
   logic              w_grant;
   logic              w_adv;

   assign w_grant = r_wreq & bus.wgnt;
   // The output register can take a new byte when empty or being granted.
   assign w_adv   = ~r_wreq | bus.wgnt;

   // Refill the one-entry read stage whenever it is empty or being consumed;
   // this starts during HEADER so data byte 0 is ready when the header ends.
   assign w_fetch = ((r_state == HEADER) || (r_state == DATA)) &&
                    (r_fetch_addr != FULL_CNT) && (~r_q_valid | w_take);

   // State and output registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_wreq  <= 1'b0;
         r_wdata <= 8'h00;
         r_hidx  <= 4'd0;
         r_tidx  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wreq  <= w_wreq_nxt;
         r_wdata <= w_wdata_nxt;
         r_hidx  <= w_hidx_nxt;
         r_tidx  <= w_tidx_nxt;
      end
   end

   // Next-state and next-output decode for the dump sequence.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      w_state_nxt = r_state;
      w_wreq_nxt  = r_wreq;
      w_wdata_nxt = r_wdata;
      w_hidx_nxt  = r_hidx;
      w_tidx_nxt  = r_tidx;
      w_take      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.in_done) begin
               if (HEADER_EN) begin
                  w_state_nxt = HEADER;
                  w_wreq_nxt  = 1'b1;
                  w_wdata_nxt = 8'h53;
                  w_hidx_nxt  = 4'd0;
               end else begin
                  w_state_nxt = DATA;
               end
            end
         end
         HEADER: begin
            if (w_grant) begin
               if (r_hidx == 4'd10) begin
                  w_state_nxt = DATA;
                  w_wreq_nxt  = r_q_valid;
                  w_take      = r_q_valid;
                  if (r_q_valid) w_wdata_nxt = r_rd_q;
               end else begin
                  w_hidx_nxt  = r_hidx + 4'd1;
                  w_wdata_nxt = hdr_byte(r_hidx + 4'd1, r_sector);
               end
            end
         end
         DATA: begin
            if (w_grant && (r_cnt == LAST_CNT)) begin
               if (TRAILER_EN) begin
                  w_state_nxt = TRAILER;
                  w_wdata_nxt = 8'h0D;
                  w_tidx_nxt  = 1'b0;
               end else begin
                  w_state_nxt = IDLE;
                  w_wreq_nxt  = 1'b0;
               end
            end else if (w_adv) begin
               w_wreq_nxt = r_q_valid;
               w_take     = r_q_valid;
               if (r_q_valid) w_wdata_nxt = r_rd_q;
            end
         end
         TRAILER: begin
            if (w_grant) begin
               if (!r_tidx) begin
                  w_tidx_nxt  = 1'b1;
                  w_wdata_nxt = 8'h0A;
               end else begin
                  w_state_nxt = IDLE;
                  w_wreq_nxt  = 1'b0;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Sector latch, fetch pointer, data counter and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sector     <= 32'h0;
         r_fetch_addr <= '0;
         r_cnt        <= '0;
         r_q_valid    <= 1'b0;
         r_overrun    <= 1'b0;
      end else if (r_state == IDLE) begin
         r_fetch_addr <= '0;
         r_cnt        <= '0;
         r_q_valid    <= 1'b0;
         if (bus.in_done) r_sector <= bus.in_sector;
      end else begin
         if (bus.in_valid || bus.in_done) r_overrun <= 1'b1;
         if (w_fetch) begin
            r_fetch_addr <= r_fetch_addr + 1'b1;
            r_q_valid    <= 1'b1;
         end else if (w_take) begin
            r_q_valid    <= 1'b0;
         end
         if ((r_state == DATA) && w_grant) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Sector buffer: written only while idle, read one cycle after fetch.
   // NOTE: the buffer has no reset so it maps onto block RAM; its contents
   // are always fully defined by the capture phase before they are read.
   always_ff @(posedge clk) begin
      if ((r_state == IDLE) && bus.in_valid) r_mem[bus.in_addr] <= bus.in_byte;
      if (w_fetch) r_rd_q <= r_mem[r_fetch_addr[ADDR_W-1:0]];
   end

   assign bus.wreq  = r_wreq;
   assign bus.wdata = r_wdata;
   assign busy      = (r_state != IDLE);
   assign overrun   = r_overrun;
endmodule

// File: tb/tb_sd_sector_uart_dumper.sv
// Directed bench for sd_sector_uart_dumper. Instance a has header and
// trailer enabled, instance b has both disabled; both share the stimulus.
module tb_sd_sector_uart_dumper;
   logic       clk;
   logic       rst_n;
   logic       tb_in_valid;
   logic [8:0] tb_in_addr;
   logic [7:0] tb_in_byte;
   logic       tb_in_done;
   logic [31:0] tb_in_sector;
   logic       tb_wgnt;
   logic       busy_a, busy_b, overrun_a, overrun_b;

   sd_sector_uart_dumper_if #(.SECTOR_BYTES(512)) if_a ();
   sd_sector_uart_dumper_if #(.SECTOR_BYTES(512)) if_b ();

   assign if_a.in_valid  = tb_in_valid;
   assign if_a.in_addr   = tb_in_addr;
   assign if_a.in_byte   = tb_in_byte;
   assign if_a.in_done   = tb_in_done;
   assign if_a.in_sector = tb_in_sector;
   assign if_a.wgnt      = tb_wgnt;
   assign if_b.in_valid  = tb_in_valid;
   assign if_b.in_addr   = tb_in_addr;
   assign if_b.in_byte   = tb_in_byte;
   assign if_b.in_done   = tb_in_done;
   assign if_b.in_sector = tb_in_sector;
   assign if_b.wgnt      = tb_wgnt;

   sd_sector_uart_dumper #(.HEADER_EN(1'b1), .TRAILER_EN(1'b1), .SECTOR_BYTES(512)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a), .busy(busy_a), .overrun(overrun_a));

   sd_sector_uart_dumper #(.HEADER_EN(1'b0), .TRAILER_EN(1'b0), .SECTOR_BYTES(512)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b), .busy(busy_b), .overrun(overrun_b));

   // Hand-computed headers for sectors 32'h00001A2F and 32'hDEADBEEF.
   logic [7:0] hdr_tab [0:1][0:10] = '{
      '{8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A},
      '{8'h53, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A}};

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   logic [7:0] q_exp[$];
   int n_pass = 0, n_checks = 0;
   int cyc = 0, first_a = 0, last_a = 0, idle_a_cyc = -1;
   int viol_a = 0, stall_a = 0, gnt_mode = 0;
   logic prev_stall_a = 1'b0;
   logic [7:0] prev_data_a = 8'h00;
   logic wreq_at_idle = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Grant generator: off, always on, or ~30% random duty.
   always @(posedge clk) begin
      #1;
      case (gnt_mode)
         0:       tb_wgnt = 1'b0;
         1:       tb_wgnt = 1'b1;
         default: tb_wgnt = ($urandom_range(0, 99) < 30);
      endcase
   end

   // Transfer monitor plus wdata stability watch on instance a.
   always @(negedge clk) begin
      cyc++;
      if (if_a.wreq && if_a.wgnt) begin
         if (q_a.size() == 0) first_a = cyc;
         last_a = cyc;
         q_a.push_back(if_a.wdata);
      end
      if (if_b.wreq && if_b.wgnt) q_b.push_back(if_b.wdata);
      if (!rst_n) begin
         prev_stall_a = 1'b0;
      end else begin
         if (prev_stall_a && (!if_a.wreq || (if_a.wdata !== prev_data_a))) viol_a++;
         if (if_a.wreq && !if_a.wgnt) stall_a++;
         prev_stall_a = if_a.wreq && !if_a.wgnt;
         prev_data_a  = if_a.wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic fill(input bit desc, input logic [7:0] xr);
      for (int k = 0; k < 512; k++) begin
         int i;
         i = desc ? (511 - k) : k;
         @(posedge clk); #1;
         tb_in_valid = 1'b1;
         tb_in_addr  = 9'(i);
         tb_in_byte  = 8'(i) ^ xr;
      end
      @(posedge clk); #1;
      tb_in_valid = 1'b0;
   endtask

   task automatic start(input logic [31:0] sec);
      @(posedge clk); #1;
      tb_in_done   = 1'b1;
      tb_in_sector = sec;
      @(posedge clk); #1;
      tb_in_done   = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      idle_a_cyc = -1;
      do begin
         @(negedge clk); #1;
         n++;
         if (!busy_a && (idle_a_cyc < 0)) begin
            idle_a_cyc   = cyc;
            wreq_at_idle = if_a.wreq;
         end
      end while ((busy_a || busy_b) && (n < budget));
      check({tag, "_idle_in_budget"}, {31'h0, busy_a | busy_b}, 32'h0);
   endtask

   task automatic wait_grants(input string tag, input int n_min, input int budget);
      int n = 0;
      while ((q_a.size() < n_min) && (n < budget)) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_grants_in_budget"}, {31'h0, q_a.size() >= n_min}, 32'h1);
   endtask

   task automatic build_exp(input bit hdr, input int sel, input bit trl, input logic [7:0] xr);
      q_exp.delete();
      if (hdr) for (int i = 0; i < 11; i++) q_exp.push_back(hdr_tab[sel][i]);
      for (int i = 0; i < 512; i++) q_exp.push_back(8'(i) ^ xr);
      if (trl) begin
         q_exp.push_back(8'h0D);
         q_exp.push_back(8'h0A);
      end
   endtask

   task automatic cmp_stream(input string tag, input bit use_b);
      int sz;
      int nbad = 0;
      logic [7:0] g;
      sz = use_b ? q_b.size() : q_a.size();
      check({tag, "_len"}, sz, q_exp.size());
      for (int i = 0; (i < sz) && (i < q_exp.size()); i++) begin
         g = use_b ? q_b[i] : q_a[i];
         if (g !== q_exp[i]) nbad++;
      end
      check({tag, "_bad_bytes"}, nbad, 0);
   endtask

   task automatic clear_q();
      q_a.delete();
      q_b.delete();
   endtask

   initial begin
      rst_n        = 1'b0;
      tb_in_valid  = 1'b0;
      tb_in_addr   = 9'h0;
      tb_in_byte   = 8'h0;
      tb_in_done   = 1'b0;
      tb_in_sector = 32'h0;
      tb_wgnt      = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      check("rst_wreq",    {31'h0, if_a.wreq}, 32'h0);
      check("rst_wdata",   {24'h0, if_a.wdata}, 32'h0);
      check("rst_busy",    {31'h0, busy_a}, 32'h0);
      check("rst_overrun", {31'h0, overrun_a}, 32'h0);

      // Full-rate dump of an ascending sector.
      fill(1'b0, 8'h00);
      gnt_mode = 1;
      clear_q();
      start(32'h0000_1A2F);
      wait_idle("s1", 2000);
      build_exp(1'b1, 0, 1'b1, 8'h00);
      cmp_stream("s1_a", 1'b0);
      check("s1_no_gaps", last_a - first_a + 1, 525);
      check("s1_busy_fall_gap", idle_a_cyc - last_a, 1);
      check("s1_wreq_at_idle", {31'h0, wreq_at_idle}, 32'h0);

      // Same sector under ~30% grant duty.
      gnt_mode = 2;
      clear_q();
      viol_a  = 0;
      stall_a = 0;
      start(32'h0000_1A2F);
      wait_idle("s2", 6000);
      cmp_stream("s2_a", 1'b0);
      check("s2_wdata_stable", viol_a, 0);
      check("s2_stalls_seen", {31'h0, stall_a > 0}, 32'h1);

      // Raw instance, reverse-order fill.
      gnt_mode = 1;
      fill(1'b1, 8'hA5);
      clear_q();
      start(32'h0000_0000);
      wait_idle("s3", 2000);
      build_exp(1'b0, 0, 1'b0, 8'hA5);
      cmp_stream("s3_b", 1'b1);

      // Overrun: write and a second in_done while instance a is in DATA.
      fill(1'b0, 8'h00);
      clear_q();
      start(32'h0000_1A2F);
      wait_grants("s4", 20, 200);
      @(posedge clk); #1;
      tb_in_valid = 1'b1;
      tb_in_addr  = 9'd5;
      tb_in_byte  = 8'hEE;
      @(posedge clk); #1;
      tb_in_valid  = 1'b0;
      tb_in_done   = 1'b1;
      tb_in_sector = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      tb_in_done = 1'b0;
      check("s4_overrun_set", {31'h0, overrun_a}, 32'h1);
      wait_idle("s4", 2000);
      build_exp(1'b1, 0, 1'b1, 8'h00);
      cmp_stream("s4_a", 1'b0);
      repeat (20) @(negedge clk);
      #1;
      check("s4_no_second_dump", q_a.size(), 525);
      check("s4_still_idle", {31'h0, busy_a}, 32'h0);
      check("s4_overrun_sticky", {31'h0, overrun_a}, 32'h1);

      // Same-cycle write of the last byte and in_done.
      clear_q();
      @(posedge clk); #1;
      tb_in_valid  = 1'b1;
      tb_in_addr   = 9'd511;
      tb_in_byte   = 8'h7E;
      tb_in_done   = 1'b1;
      tb_in_sector = 32'h0000_1A2F;
      @(posedge clk); #1;
      tb_in_valid = 1'b0;
      tb_in_done  = 1'b0;
      wait_idle("s5", 2000);
      check("s5_a_len", q_a.size(), 525);
      check("s5_b_len", q_b.size(), 512);
      if (q_a.size() == 525) check("s5_a_last_data", {24'h0, q_a[522]}, 32'h7E);
      if (q_b.size() == 512) check("s5_b_last_data", {24'h0, q_b[511]}, 32'h7E);

      // Reset in the middle of DATA, then a fresh sector.
      clear_q();
      start(32'h0000_1A2F);
      wait_grants("s6", 100, 400);
      rst_n = 1'b0;
      #1;
      check("s6_rst_wreq",    {31'h0, if_a.wreq}, 32'h0);
      check("s6_rst_busy",    {31'h0, busy_a}, 32'h0);
      check("s6_rst_overrun", {31'h0, overrun_a}, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_q();
      fill(1'b0, 8'h3C);
      start(32'hDEAD_BEEF);
      wait_idle("s6", 2000);
      build_exp(1'b1, 1, 1'b1, 8'h3C);
      cmp_stream("s6_a", 1'b0);
      build_exp(1'b0, 0, 1'b0, 8'h3C);
      cmp_stream("s6_b", 1'b1);
      check("s6_overrun_clear", {31'h0, overrun_a}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
